// File: rtl/weight_fetcher_pkg.sv
// Shared types and constants for the weight fetch path: the row type, the fetcher
// FSM states and the job row-count helper.
package weight_fetcher_pkg;

  localparam int W_WIDTH      = 7;
  localparam int WF_LANES     = 32;
  localparam int WF_TILE_ROWS = 32;
  localparam int WF_ADDR_W    = 16;
  localparam int WF_NT_W      = 8;

  typedef logic [WF_LANES-1:0][W_WIDTH:0] weight_row_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } fetch_state_e;

  // Rows in a job; the counter is wide enough that 255 full tiles never overflow it.
  function automatic logic [12:0] job_rows(input logic [WF_NT_W-1:0] num_tiles);
    return 13'(num_tiles) * 13'(WF_TILE_ROWS);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry row FIFO with a registered head. It absorbs the one-cycle read latency
// of a synchronous memory so rows can stream at full rate.
module fetch_skid_buf #(
  parameter int WIDTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       occ_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
    end else begin
      occ_q <= occ_q + 2'(push) - 2'(pop);
      if (pop && occ_q == 2'd2) begin
        head_q <= tail_q;
      end else if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) begin
        head_q <= push_data;
      end
    end
  end

  // NOTE: the tail entry is never observable before it is written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push && (occ_q == 2'd2 || (occ_q == 2'd1 && !pop))) begin
      tail_q <= push_data;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/weight_fetcher.sv
// Walks weight memory one row per read for num_tiles*TILE_ROWS rows and feeds them
// to the weight FIFO write port through a two-entry skid buffer.
module weight_fetcher
  import weight_fetcher_pkg::*;
#(
  parameter int LANES     = WF_LANES,
  parameter int ADDR_W    = WF_ADDR_W,
  parameter int TILE_ROWS = WF_TILE_ROWS,
  parameter int NT_W      = WF_NT_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ADDR_W-1:0]           base_addr_i,
  input  logic [NT_W-1:0]             num_tiles_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        mem_rd_en_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  input  logic [LANES-1:0][W_WIDTH:0] mem_data_i,
  output logic                        write_en_o,
  input  logic                        request_i,
  output logic                        sending_o,
  output logic [LANES-1:0][W_WIDTH:0] data_o
);

  localparam int CNT_W = NT_W + $clog2(TILE_ROWS);
  localparam int ROW_W = LANES * (W_WIDTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  delivered_q;
  logic              inflight_q;

  logic [1:0]        occ;
  logic [ROW_W-1:0]  head;
  logic              pop;
  logic              rd_en;
  logic [2:0]        level_after;

  assign sending_o   = (occ != 2'd0);
  assign pop         = request_i & sending_o;
  // Rows held or in flight once this cycle's pop leaves; never lets the buffer exceed 2.
  assign level_after = 3'(occ) + 3'(inflight_q) - 3'(pop);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    busy_o     = (state_q != IDLE);
    done_o     = 1'b0;
    write_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_tiles_i != '0) ? FETCH : FINISH;
        end
      end
      FETCH: begin
        rd_en      = (level_after < 3'd2);
        write_en_o = (delivered_q != total_q);
        if (rd_en && issued_q == total_q - CNT_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        write_en_o = (delivered_q != total_q);
        if (delivered_q == total_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (state_q == IDLE && start_i) begin
        addr_q      <= base_addr_i;
        total_q     <= CNT_W'(job_rows(num_tiles_i));
        issued_q    <= '0;
        delivered_q <= '0;
      end else begin
        if (rd_en) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + CNT_W'(1);
        end
        if (pop) begin
          delivered_q <= delivered_q + CNT_W'(1);
        end
      end
    end
  end

  fetch_skid_buf #(
    .WIDTH(ROW_W)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (inflight_q),
    .push_data(mem_data_i),
    .pop      (pop),
    .occ      (occ),
    .head     (head)
  );

  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = addr_q;
  assign data_o      = head;

endmodule

// File: tb/tb_weight_fetcher.sv
// Directed bench for weight_fetcher: a behavioural one-cycle-latency memory plus
// per-job statistics compared against hand-derived cycle numbers and row contents.
module tb_weight_fetcher;
  import weight_fetcher_pkg::*;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic [15:0]       base_addr_i;
  logic [7:0]        num_tiles_i;
  logic              busy_o;
  logic              done_o;
  logic              mem_rd_en_o;
  logic [15:0]       mem_addr_o;
  weight_row_t       mem_data_i;
  logic              write_en_o;
  logic              request_i;
  logic              sending_o;
  weight_row_t       data_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-job statistics filled by run_job.
  int first_rd, last_rd, rd_cnt, stall_rd, addr_errs;
  int first_snd, last_snd, snd_cnt;
  int we_cnt, last_we;
  int pops, row_errs, hold_errs, max_lvl;
  int done_cnt, done_cyc;
  logic [7:0] rst_outs;

  weight_fetcher dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .num_tiles_i(num_tiles_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .write_en_o (write_en_o),
    .request_i  (request_i),
    .sending_o  (sending_o),
    .data_o     (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic weight_row_t row_of(input logic [15:0] a);
    return {WF_LANES{a[7:0]}};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en_o) mem_data_i <= row_of(mem_addr_o);
  end

  task automatic check(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Cycle 0 is the cycle start_i is high. Outputs are sampled at the falling edge.
  task automatic run_job(input logic [15:0] base, input logic [7:0] tiles,
                         input int stall_lo, input int stall_hi,
                         input int rst_cyc, input int s1, input int s2);
    logic [15:0] a;
    logic        pop, hold_prev, st;
    weight_row_t prev_data;
    first_rd = -1; last_rd = -1; rd_cnt = 0; stall_rd = 0; addr_errs = 0;
    first_snd = -1; last_snd = -1; snd_cnt = 0; we_cnt = 0; last_we = -1;
    pops = 0; row_errs = 0; hold_errs = 0; max_lvl = 0;
    done_cnt = 0; done_cyc = -1; rst_outs = 8'hFF;
    hold_prev = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; num_tiles_i = tiles;
    request_i = !(stall_lo <= 0 && 0 <= stall_hi);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      pop = request_i & sending_o;
      if (mem_rd_en_o) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        if (c >= stall_lo && c <= stall_hi) stall_rd++;
        a = base + 16'(rd_cnt);
        if (mem_addr_o !== a) addr_errs++;
        rd_cnt++;
      end
      if (sending_o) begin
        if (first_snd < 0) first_snd = c;
        last_snd = c;
        snd_cnt++;
      end
      if (write_en_o) begin
        we_cnt++;
        last_we = c;
      end
      if (hold_prev && sending_o && data_o !== prev_data) hold_errs++;
      hold_prev = sending_o & ~request_i;
      prev_data = data_o;
      if (pop) begin
        a = base + 16'(pops);
        if (data_o !== row_of(a)) row_errs++;
        pops++;
      end
      if (rd_cnt - pops > max_lvl) max_lvl = rd_cnt - pops;
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1)
        rst_outs = {busy_o, done_o, write_en_o, sending_o, mem_rd_en_o,
                    |mem_addr_o, |data_o, 1'b0};
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      if (rst_cyc >= 0 && c >= rst_cyc + 4) break;
      @(posedge clk); #1;
      st = (c + 1 == s1) || (c + 1 == s2);
      start_i     = st;
      base_addr_i = st ? (base ^ 16'h5555) : base;
      num_tiles_i = st ? (tiles + 8'd3) : tiles;
      request_i   = !(stall_lo <= c + 1 && c + 1 <= stall_hi);
      rst_i       = !(c + 1 == rst_cyc);
    end
    start_i = 1'b0;
    request_i = 1'b1;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; base_addr_i = '0; num_tiles_i = '0;
    request_i = 1'b1; mem_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_we", write_en_o, 0);
    check("rst_sending", sending_o, 0);
    check("rst_rd_en", mem_rd_en_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    // One tile, no backpressure: exact latency and throughput.
    run_job(16'h0100, 8'd1, -1, -2, -1, -1, -1);
    check("t1_first_rd", first_rd, 1);
    check("t1_last_rd", last_rd, 32);
    check("t1_rd_cnt", rd_cnt, 32);
    check("t1_first_snd", first_snd, 3);
    check("t1_last_snd", last_snd, 34);
    check("t1_last_we", last_we, 34);
    check("t1_pops", pops, 32);
    check("t1_row_errs", row_errs, 0);
    check("t1_addr_errs", addr_errs, 0);
    check("t1_done_cyc", done_cyc, 36);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_max_lvl", max_lvl <= 2, 1);

    // FIFO full during cycles 5..14: reads stall once two rows are held, head stays put.
    run_job(16'h0500, 8'd1, 5, 14, -1, -1, -1);
    check("bp_stall_rd", stall_rd, 0);
    check("bp_hold_errs", hold_errs, 0);
    check("bp_pops", pops, 32);
    check("bp_row_errs", row_errs, 0);
    check("bp_max_lvl", max_lvl <= 2, 1);
    check("bp_done_cnt", done_cnt, 1);

    // Empty job: finishes without touching memory or the FIFO.
    run_job(16'h0700, 8'd0, -1, -2, -1, -1, -1);
    check("z_rd_cnt", rd_cnt, 0);
    check("z_snd_cnt", snd_cnt, 0);
    check("z_we_cnt", we_cnt, 0);
    check("z_done_cnt", done_cnt, 1);
    check("z_done_early", (done_cyc >= 1) && (done_cyc <= 2), 1);

    // Address wrap from 0xFFF0 through 0x000F.
    run_job(16'hFFF0, 8'd1, -1, -2, -1, -1, -1);
    check("wrap_addr_errs", addr_errs, 0);
    check("wrap_row_errs", row_errs, 0);
    check("wrap_pops", pops, 32);
    check("wrap_done_cnt", done_cnt, 1);

    // Reset in cycle 10 of a two-tile job, then a fresh two-tile job.
    run_job(16'h0200, 8'd2, -1, -2, 10, -1, -1);
    check("rst_mid_outs", rst_outs, 0);
    check("rst_mid_no_done", done_cnt, 0);
    run_job(16'h0300, 8'd2, -1, -2, -1, -1, -1);
    check("after_rst_pops", pops, 64);
    check("after_rst_row_errs", row_errs, 0);
    check("after_rst_addr_errs", addr_errs, 0);
    check("after_rst_done_cnt", done_cnt, 1);

    // Start pulses while busy carry a different base and count and must be ignored.
    run_job(16'h0400, 8'd1, -1, -2, -1, 3, 20);
    check("ign_pops", pops, 32);
    check("ign_row_errs", row_errs, 0);
    check("ign_rd_cnt", rd_cnt, 32);
    check("ign_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
